// File: rtl/elastic_pipe.sv
// elastic_pipe
// Multi-stage register pipeline with valid/ready flow control between the
// I/O pins and internal logic. Each stage holds one word. A combinational
// ready chain lets empty stages (bubbles) be filled while the stages ahead
// of them are stalled. A synchronous flush discards every held word.
//
// Optional feature macro: ELASTIC_PIPE_OCC_EN
//   defined   -> occupancy is a registered count of valid stages
//   undefined -> occupancy is tied to zero and no counter is built
//
// Stage 0 is the input side and stage STAGES-1 is the output side.

module elastic_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;

    // Ready chain: a stage can load when it is empty or when the stage ahead
    // of it can load. A running variable is used so that no bit of rdy
    // depends on another bit of rdy.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int i = STAGES-1; i >= 0; i--) begin
            chain  = !v_q[i] || chain;
            rdy[i] = chain;
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v_q[STAGES-1] && !flush;
    assign out_data  = data_q[STAGES-1];

    // Stage registers: every ready stage takes the contents of the stage
    // behind it; data only moves when a real word moves, so empty shifts
    // leave the old data in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (rdy[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end

`ifdef ELASTIC_PIPE_OCC_EN
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Occupancy counter: tracks accepted minus emitted words; a simultaneous
    // accept and emit leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model of the
// words in flight (each word carries its stage position).

module tb_elastic_pipe;

    localparam int W = 8;
    localparam int S = 3;
`ifdef ELASTIC_PIPE_OCC_EN
    localparam bit OCC_ON = 1'b1;
`else
    localparam bit OCC_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         flush;
    logic [1:0]   occupancy;

    logic [W-1:0] s1_in_data;
    logic         s1_in_valid;
    logic         s1_in_ready;
    logic [W-1:0] s1_out_data;
    logic         s1_out_valid;
    logic         s1_out_ready;
    logic         s1_flush;
    logic [0:0]   s1_occupancy;

    elastic_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy)
    );

    elastic_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(s1_in_data), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .out_data(s1_out_data), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .flush(s1_flush), .occupancy(s1_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int recv[$];
    int recv_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // Words in flight, front = oldest; each has a stage position 0..S-1.
    int mq_data[$];
    int mq_pos[$];
    int np[$];
    int nd[$];
    int last_out = 0;
    bit blk, blk_prev, acc;
    int newp;

    always @(posedge clk) begin
        if (rst) begin
            mq_data.delete();
            mq_pos.delete();
            last_out = 0;
        end else if (flush) begin
            mq_data.delete();
            mq_pos.delete();
        end else begin
            acc = in_valid && (mq_pos.size() < S || out_ready);
            np.delete();
            nd.delete();
            blk_prev = 1'b0;
            for (int k = 0; k < mq_pos.size(); k++) begin
                if (k == 0) blk = (mq_pos[0] == S-1) && !out_ready;
                else        blk = blk_prev && (mq_pos[k] + 1 == mq_pos[k-1]);
                newp = blk ? mq_pos[k] : mq_pos[k] + 1;
                if (newp < S) begin
                    np.push_back(newp);
                    nd.push_back(mq_data[k]);
                    if (!blk && newp == S-1) last_out = mq_data[k];
                end
                blk_prev = blk;
            end
            if (acc) begin
                np.push_back(0);
                nd.push_back(int'(in_data));
            end
            mq_pos  = np;
            mq_data = nd;
        end
    end

    // ---------------- per-cycle compare ----------------
    int exp_ir, exp_ov, exp_occ;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_ir = (!flush && (mq_pos.size() < S || out_ready)) ? 1 : 0;
            exp_ov = 0;
            if (!flush && mq_pos.size() > 0) begin
                if (mq_pos[0] == S-1) exp_ov = 1;
            end
            exp_occ = OCC_ON ? mq_pos.size() : 0;
            check("in_ready", int'(in_ready), exp_ir);
            check("out_valid", int'(out_valid), exp_ov);
            check("out_data", int'(out_data), last_out);
            check("occupancy", int'(occupancy), exp_occ);
            if (out_valid && out_ready) begin
                recv.push_back(int'(out_data));
                recv_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    int cnt;
    int first_in_cyc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        s1_in_data = '0; s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_flush = 1'b0;

        // Reset then idle
        step();
        chk_en = 1'b1;
        step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt++;
            if (out_valid) break;
        end
        check("rst_first_out_latency", cnt, 3);
        check("rst_first_out_data", int'(out_data), 8'hAA);
        in_valid = 1'b0;
        repeat (5) step();

        // Streaming 0x01..0x10
        recv.delete(); recv_cyc.delete();
        first_in_cyc = cyc;
        for (int v = 1; v <= 16; v++) begin
            in_valid = 1'b1;
            in_data  = W'(v);
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        check("stream_count", recv.size(), 16);
        if (recv.size() == 16) begin
            check("stream_latency", recv_cyc[0] - first_in_cyc, 3);
            for (int i = 0; i < 16; i++) begin
                check("stream_data", recv[i], i + 1);
                check("stream_no_gap", recv_cyc[i] - recv_cyc[0], i);
            end
        end

        // Backpressure and fill
        out_ready = 1'b0;
        for (int v = 8'h21; v <= 8'h23; v++) begin
            in_valid = 1'b1;
            in_data  = W'(v);
            #1;
            check("fill_in_ready", int'(in_ready), 1);
            step();
        end
        in_data = 8'h24;
        #1;
        check("full_in_ready", int'(in_ready), 0);
        check("full_occupancy", int'(occupancy), OCC_ON ? 3 : 0);
        step();
        step();
        check("stall_out_data", int'(out_data), 8'h21);
        recv.delete();
        out_ready = 1'b1;
        #1;
        check("full_release_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        repeat (6) step();
        check("bp_count", recv.size(), 4);
        if (recv.size() == 4) begin
            for (int i = 0; i < 4; i++) check("bp_data", recv[i], 8'h21 + i);
        end

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h31; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h32; step();
        in_valid = 1'b0; step();
        check("bubble_occupancy", int'(occupancy), OCC_ON ? 2 : 0);
        check("bubble_out_valid", int'(out_valid), 1);
        check("bubble_out_data", int'(out_data), 8'h31);
        check("bubble_in_ready", int'(in_ready), 1);
        recv.delete();
        out_ready = 1'b1;
        repeat (5) step();
        check("bubble_count", recv.size(), 2);
        if (recv.size() == 2) begin
            check("bubble_first", recv[0], 8'h31);
            check("bubble_second", recv[1], 8'h32);
        end

        // Flush mid-stream
        out_ready = 1'b0;
        for (int v = 8'h41; v <= 8'h43; v++) begin
            in_valid = 1'b1; in_data = W'(v); step();
        end
        recv.delete();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        #1;
        check("flush_in_ready", int'(in_ready), 0);
        check("flush_out_valid", int'(out_valid), 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("post_flush_occupancy", int'(occupancy), 0);
        check("post_flush_out_valid", int'(out_valid), 0);
        check("post_flush_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (4) step();
        check("flush_dropped_all", recv.size(), 0);
        in_valid = 1'b1; in_data = 8'h45; step();
        in_valid = 1'b0;
        repeat (5) step();
        check("post_flush_count", recv.size(), 1);
        if (recv.size() == 1) check("post_flush_data", recv[0], 8'h45);

        // STAGES=1 corner
        s1_out_ready = 1'b0; s1_in_valid = 1'b1; s1_in_data = 8'h55;
        #1;
        check("s1_accept_ready", int'(s1_in_ready), 1);
        step();
        s1_in_valid = 1'b0;
        #1;
        check("s1_held_valid", int'(s1_out_valid), 1);
        check("s1_held_data", int'(s1_out_data), 8'h55);
        check("s1_full_in_ready", int'(s1_in_ready), 0);
        s1_out_ready = 1'b1; s1_in_valid = 1'b1; s1_in_data = 8'h56;
        #1;
        check("s1_swap_in_ready", int'(s1_in_ready), 1);
        check("s1_swap_out_valid", int'(s1_out_valid), 1);
        check("s1_swap_out_data", int'(s1_out_data), 8'h55);
        step();
        s1_in_valid = 1'b0; s1_out_ready = 1'b0;
        #1;
        check("s1_next_valid", int'(s1_out_valid), 1);
        check("s1_next_data", int'(s1_out_data), 8'h56);
        check("s1_occupancy", int'(s1_occupancy), OCC_ON ? 1 : 0);

        // Randomized run against the model
        recv.delete();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        check("rand_transfers_seen", (recv.size() > 100) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
